// File: rtl/clk_gate_ctrl.sv
// clk_gate_ctrl: request-driven clock-enable controller with wake latency,
// idle hold-off before gating, and a saturating active-cycle counter.
module clk_gate_ctrl #(
  parameter int NREQ     = 4,
  parameter int WAKE_CYC = 2,
  parameter int IDLE_CYC = 8,
  parameter int CNT_W    = 16
) (
  input  logic             mst_clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req,
  input  logic             force_on,
  input  logic             cnt_clr,
  output logic             clk_en,
  output logic [NREQ-1:0]  ack,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] on_cnt
);
  typedef enum logic [1:0] {OFF = 2'd0, WAKE = 2'd1, ON = 2'd2, HOLD = 2'd3} state_t;
  state_t           r_state, w_state;
  logic             r_clk_en, w_clk_en;
  logic [NREQ-1:0]  r_ack, w_ack;
  logic [3:0]       r_wcnt, w_wcnt;
  logic [7:0]       r_icnt, w_icnt;
  logic [CNT_W-1:0] r_cnt;
  logic             w_any;
  assign w_any = |req;
  // clk_en only moves on OFF->WAKE and HOLD->OFF; ack is zero unless ON is entered/held
  always_comb begin
    w_state  = r_state;
    w_clk_en = r_clk_en;
    w_ack    = '0;
    w_wcnt   = r_wcnt;
    w_icnt   = r_icnt;
    case (r_state)
      OFF:
        if (w_any || force_on) begin
          w_state  = WAKE;
          w_clk_en = 1'b1;
          w_wcnt   = 4'(WAKE_CYC - 1);
        end
      WAKE:
        if (r_wcnt != 4'd0) w_wcnt = r_wcnt - 4'd1;
        else if (w_any) begin
          w_state = ON;
          w_ack   = req;
        end else begin
          w_state = HOLD;
          w_icnt  = 8'(IDLE_CYC - 1);
        end
      ON:
        if (w_any) w_ack = req;
        else begin
          w_state = HOLD;
          w_icnt  = 8'(IDLE_CYC - 1);
        end
      HOLD:
        if (w_any) begin
          w_state = ON;
          w_ack   = req;
        end else if (r_icnt != 8'd0) w_icnt = r_icnt - 8'd1;
        else if (!force_on) begin
          w_state  = OFF;
          w_clk_en = 1'b0;
        end
      default: begin
        w_state  = OFF;
        w_clk_en = 1'b0;
      end
    endcase
  end
  always_ff @(posedge mst_clk) begin
    if (!rst_n) begin
      r_state  <= OFF;
      r_clk_en <= 1'b0;
      r_ack    <= '0;
      r_wcnt   <= 4'd0;
      r_icnt   <= 8'd0;
    end else begin
      r_state  <= w_state;
      r_clk_en <= w_clk_en;
      r_ack    <= w_ack;
      r_wcnt   <= w_wcnt;
      r_icnt   <= w_icnt;
    end
  end
  // counts edges where the enable was already high; clear wins, saturates at all-ones
  always_ff @(posedge mst_clk) begin
    if (!rst_n || cnt_clr) r_cnt <= '0;
    else if (r_clk_en && !(&r_cnt)) r_cnt <= r_cnt + 1'b1;
  end
  assign clk_en = r_clk_en;
  assign ack    = r_ack;
  assign state  = r_state;
  assign on_cnt = r_cnt;
endmodule

// File: tb/tb_clk_gate_ctrl.sv
// tb_clk_gate_ctrl: directed vectors checked by a negedge monitor against two DUT instances
module tb_clk_gate_ctrl;
  logic mst_clk = 1'b0;
  always #5 mst_clk = ~mst_clk;
  logic        rst_n, force_on, cnt_clr;
  logic [3:0]  req;
  logic        clk_en;
  logic [3:0]  ack;
  logic [1:0]  state;
  logic [15:0] on_cnt;
  logic        s_rst_n, s_force, s_clr;
  logic [3:0]  s_req;
  logic        s_clk_en;
  logic [3:0]  s_ack;
  logic [1:0]  s_state;
  logic [3:0]  s_cnt;
  clk_gate_ctrl u_dut (
    .mst_clk(mst_clk), .rst_n(rst_n), .req(req), .force_on(force_on), .cnt_clr(cnt_clr),
    .clk_en(clk_en), .ack(ack), .state(state), .on_cnt(on_cnt)
  );
  clk_gate_ctrl #(.CNT_W(4)) u_sat (
    .mst_clk(mst_clk), .rst_n(s_rst_n), .req(s_req), .force_on(s_force), .cnt_clr(s_clr),
    .clk_en(s_clk_en), .ack(s_ack), .state(s_state), .on_cnt(s_cnt)
  );
  typedef struct packed {
    logic        d;
    logic [1:0]  st;
    logic        ce;
    logic [3:0]  ack;
    logic [15:0] cnt;
  } exp_t;
  exp_t  q[$];
  string nq[$];
  int    checks = 0, failures = 0;
  exp_t  m_e;
  string m_nm;
  logic [1:0]  m_st;
  logic        m_ce;
  logic [3:0]  m_ack;
  logic [15:0] m_cnt;
  always @(negedge mst_clk) begin
    while (q.size() > 0) begin
      m_e   = q.pop_front();
      m_nm  = nq.pop_front();
      m_st  = m_e.d ? s_state : state;
      m_ce  = m_e.d ? s_clk_en : clk_en;
      m_ack = m_e.d ? s_ack : ack;
      m_cnt = m_e.d ? {12'd0, s_cnt} : on_cnt;
      checks++;
      if (m_st !== m_e.st) begin
        failures++;
        $display("FAIL %s: got state=%0d, want state=%0d", m_nm, m_st, m_e.st);
      end
      if (m_ce !== m_e.ce) begin
        failures++;
        $display("FAIL %s: got clk_en=%b, want clk_en=%b", m_nm, m_ce, m_e.ce);
      end
      if (m_ack !== m_e.ack) begin
        failures++;
        $display("FAIL %s: got ack=%b, want ack=%b", m_nm, m_ack, m_e.ack);
      end
      if (m_cnt !== m_e.cnt) begin
        failures++;
        $display("FAIL %s: got on_cnt=%0d, want on_cnt=%0d", m_nm, m_cnt, m_e.cnt);
      end
    end
  end
  task automatic tick();
    @(posedge mst_clk);
    #1;
  endtask
  task automatic expect_now(input string nm, input logic d, input logic [1:0] st,
                            input logic ce, input logic [3:0] a, input int cnt);
    exp_t e;
    e.d = d; e.st = st; e.ce = ce; e.ack = a; e.cnt = 16'(cnt);
    q.push_back(e);
    nq.push_back(nm);
  endtask
  task automatic do_reset(input string nm);
    rst_n = 1'b0;
    req   = 4'd0;
    tick();
    expect_now(nm, 1'b0, 2'd0, 1'b0, 4'd0, 0);
    rst_n = 1'b1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end
  initial begin
    rst_n = 1'b0; req = 4'd0; force_on = 1'b0; cnt_clr = 1'b0;
    s_rst_n = 1'b0; s_req = 4'd0; s_force = 1'b0; s_clr = 1'b0;
    tick();
    tick();
    expect_now("reset_dut", 1'b0, 2'd0, 1'b0, 4'd0, 0);
    expect_now("reset_sat", 1'b1, 2'd0, 1'b0, 4'd0, 0);
    rst_n = 1'b1;
    req   = 4'b0001;
    for (int e = 1; e <= 20; e++) begin
      tick();
      expect_now($sformatf("single_e%0d", e), 1'b0,
                 e <= 2 ? 2'd1 : e <= 9 ? 2'd2 : e <= 17 ? 2'd3 : 2'd0,
                 e <= 17, (e >= 3 && e <= 9) ? 4'b0001 : 4'b0000,
                 e < 18 ? e - 1 : 17);
      req = (e + 1 < 10) ? 4'b0001 : 4'b0000;
    end
    do_reset("reset_rereq");
    req = 4'b0001;
    for (int e = 1; e <= 16; e++) begin
      tick();
      expect_now($sformatf("rereq_e%0d", e), 1'b0,
                 e <= 2 ? 2'd1 : e <= 9 ? 2'd2 : e <= 13 ? 2'd3 : 2'd2,
                 1'b1, (e >= 3 && e <= 9) ? 4'b0001 : e >= 14 ? 4'b0100 : 4'b0000,
                 e - 1);
      req = (e + 1 < 10) ? 4'b0001 : (e + 1 >= 14) ? 4'b0100 : 4'b0000;
    end
    do_reset("reset_drop");
    req = 4'b0001;
    for (int e = 1; e <= 13; e++) begin
      tick();
      expect_now($sformatf("drop_e%0d", e), 1'b0,
                 e <= 2 ? 2'd1 : e <= 10 ? 2'd3 : 2'd0,
                 e <= 10, 4'b0000, e <= 11 ? e - 1 : 10);
      req = 4'b0000;
    end
    do_reset("reset_all");
    req = 4'b1111;
    for (int e = 1; e <= 4; e++) begin
      tick();
      expect_now($sformatf("all_e%0d", e), 1'b0, e <= 2 ? 2'd1 : 2'd2, 1'b1,
                 e >= 3 ? 4'b1111 : 4'b0000, e - 1);
    end
    rst_n = 1'b0; force_on = 1'b1; cnt_clr = 1'b1;
    tick();
    expect_now("midrst", 1'b0, 2'd0, 1'b0, 4'd0, 0);
    rst_n = 1'b1; force_on = 1'b0; cnt_clr = 1'b0;
    tick();
    expect_now("midrst_wake1", 1'b0, 2'd1, 1'b1, 4'd0, 0);
    tick();
    expect_now("midrst_wake2", 1'b0, 2'd1, 1'b1, 4'd0, 1);
    tick();
    expect_now("midrst_on", 1'b0, 2'd2, 1'b1, 4'b1111, 2);
    s_rst_n = 1'b1;
    s_force = 1'b1;
    for (int e = 1; e <= 25; e++) begin
      tick();
      expect_now($sformatf("force_e%0d", e), 1'b1, e <= 2 ? 2'd1 : 2'd3, 1'b1, 4'd0,
                 e - 1 > 15 ? 15 : e - 1);
    end
    s_clr = 1'b1;
    tick();
    expect_now("force_clr", 1'b1, 2'd3, 1'b1, 4'd0, 0);
    s_clr = 1'b0;
    tick();
    expect_now("force_resume1", 1'b1, 2'd3, 1'b1, 4'd0, 1);
    tick();
    expect_now("force_resume2", 1'b1, 2'd3, 1'b1, 4'd0, 2);
    s_force = 1'b0;
    tick();
    expect_now("force_release", 1'b1, 2'd0, 1'b0, 4'd0, 3);
    tick();
    expect_now("force_off", 1'b1, 2'd0, 1'b0, 4'd0, 3);
    @(negedge mst_clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
